// File: rtl/memory_access_master_pkg.sv
// Shared constants for the MEM-stage data-memory master: FSM encodings and timeout default.
package memory_access_master_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic is_word_aligned(input logic [31:0] address);
        return address[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/memory_access_master_if.sv
// CPU-side request/response and data-memory strobe/ready signals of the MEM-stage master.
interface memory_access_master_if;

    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        stall;
    logic [31:0] mem_address;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;
    logic        error;

    modport master (
        input  cpu_read, cpu_write, cpu_address, cpu_write_data, mem_read_data, mem_ready,
        output cpu_read_data, stall, mem_address, mem_read_enable, mem_write_enable,
               mem_write_data, error
    );

    modport slave (
        output cpu_read, cpu_write, cpu_address, cpu_write_data, mem_read_data, mem_ready,
        input  cpu_read_data, stall, mem_address, mem_read_enable, mem_write_enable,
               mem_write_data, error
    );

endinterface

// File: rtl/memory_access_master_access_timer.sv
// Saturating ACCESS-cycle counter; expired flags the TIMEOUT-th enabled cycle combinationally.
// Latency: count updates on posedge; clear has priority over enable.
module access_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != SAT) begin
            count <= count + CNT_W'(1);
        end
    end

    // count holds the number of completed ACCESS cycles, so LAST means this one is the final allowed
    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/memory_access_master.sv
// MEM-stage data-memory master: registered strobes held until mem_ready, sticky error, TIMEOUT abort.
// Latency: request to DONE in 2 posedges minimum; stall freezes the pipeline while a request waits.
module memory_access_master
    import memory_access_master_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    memory_access_master_if.master bus
);

    state_t      state, state_nxt;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        error_q, error_d;
    logic        single_req, valid_req, bad_req;
    logic        timer_clear, timer_expired;

    assign single_req = bus.cpu_read ^ bus.cpu_write;
    assign valid_req  = single_req && is_word_aligned(bus.cpu_address) && !error_q;
    assign bad_req    = !error_q && (bus.cpu_read || bus.cpu_write) && !valid_req;

    access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (state == ACCESS),
        .expired (timer_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;
        error_d     = error_q;
        timer_clear = 1'b0;
        case (state)
            IDLE: begin
                if (valid_req) begin
                    addr_d      = bus.cpu_address;
                    wdata_d     = bus.cpu_write_data;
                    rd_en_d     = bus.cpu_read;
                    wr_en_d     = bus.cpu_write;
                    timer_clear = 1'b1;
                    state_nxt   = ACCESS;
                end else if (bad_req) begin
                    error_d = 1'b1;
                end
            end
            ACCESS: begin
                // A completion on the last allowed cycle still counts as a success
                if (bus.mem_ready) begin
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    if (rd_en_q) rdata_d = bus.mem_read_data;
                    state_nxt = DONE;
                end else if (timer_expired) begin
                    rd_en_d   = 1'b0;
                    wr_en_d   = 1'b0;
                    rdata_d   = '0;
                    error_d   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            error_q <= error_d;
        end
    end

    // Gated by reset so a held request cannot freeze the pipeline during reset
    assign bus.stall            = reset && ((state == IDLE && valid_req) || state == ACCESS);
    assign bus.mem_address      = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign bus.mem_read_enable  = rd_en_q;
    assign bus.mem_write_enable = wr_en_q;
    assign bus.cpu_read_data    = rdata_q;
    assign bus.error            = error_q;

endmodule

// File: tb/tb_memory_access_master.sv
// Directed bench for memory_access_master: transaction table plus reset, back-to-back and sticky-error sequences.
module tb_memory_access_master;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_commits = 0;

    memory_access_master_if bus();

    memory_access_master #(.TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.mem_write_enable && bus.mem_ready) wr_commits <= wr_commits + 1;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          delay;
        int          exp_stall;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_done;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_write_data = '0;
        bus.mem_ready = 1'b0;
        bus.mem_read_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset mem_read_enable", {31'b0, bus.mem_read_enable}, 32'd0);
        check("reset mem_write_enable", {31'b0, bus.mem_write_enable}, 32'd0);
        check("reset mem_address", bus.mem_address, 32'd0);
        check("reset mem_write_data", bus.mem_write_data, 32'd0);
        check("reset cpu_read_data", bus.cpu_read_data, 32'd0);
        check("reset error", {31'b0, bus.error}, 32'd0);
        check("reset stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          stall_cnt = 0, rd_cnt = 0, wr_cnt = 0, strobe_cnt = 0;
        int          overlap = 0, unstable = 0, commits0;
        logic        stall_prev, done_seen = 1'b0, done_stall = 1'b0, in_done;
        logic [31:0] a0 = '0, d0 = '0, done_rdata = '0;
        do_reset();
        commits0 = wr_commits;
        bus.cpu_read = v.rd;
        bus.cpu_write = v.wr;
        bus.cpu_address = v.addr;
        bus.cpu_write_data = v.wdata;
        bus.mem_ready = 1'b1;
        bus.mem_read_data = 32'hDEAD_BEEF;
        #1;
        stall_prev = bus.stall;
        if (stall_prev) stall_cnt++;
        for (int c = 0; c < 24; c++) begin
            @(posedge clock);
            #1;
            in_done = 1'b0;
            // Pipeline advances on any edge where stall was low
            if (!stall_prev) begin
                bus.cpu_read = 1'b0;
                bus.cpu_write = 1'b0;
            end
            if (bus.mem_read_enable || bus.mem_write_enable) begin
                strobe_cnt++;
                if (bus.mem_read_enable) rd_cnt++;
                if (bus.mem_write_enable) wr_cnt++;
                if (bus.mem_read_enable && bus.mem_write_enable) overlap++;
                if (strobe_cnt == 1) begin
                    a0 = bus.mem_address;
                    d0 = bus.mem_write_data;
                end else if (bus.mem_address !== a0 || bus.mem_write_data !== d0) begin
                    unstable++;
                end
                bus.mem_ready = (v.delay != 0 && strobe_cnt == v.delay);
                bus.mem_read_data = bus.mem_ready ? v.mdata : 32'hDEAD_BEEF;
            end else begin
                bus.mem_ready = 1'b1;
                bus.mem_read_data = 32'hDEAD_BEEF;
                if (strobe_cnt > 0 && !done_seen) begin
                    done_seen = 1'b1;
                    in_done = 1'b1;
                    done_rdata = bus.cpu_read_data;
                end
            end
            #1;
            if (bus.stall) stall_cnt++;
            if (in_done) done_stall = bus.stall;
            stall_prev = bus.stall;
        end
        check($sformatf("v%0d stall_cycles", idx), stall_cnt, v.exp_stall);
        check($sformatf("v%0d read_strobe_cycles", idx), rd_cnt, v.exp_rd);
        check($sformatf("v%0d write_strobe_cycles", idx), wr_cnt, v.exp_wr);
        check($sformatf("v%0d strobe_overlap", idx), overlap, 32'd0);
        check($sformatf("v%0d done_seen", idx), {31'b0, done_seen}, {31'b0, v.exp_done});
        check($sformatf("v%0d error", idx), {31'b0, bus.error}, {31'b0, v.exp_err});
        check($sformatf("v%0d write_commits", idx), wr_commits - commits0, (v.exp_wr > 0) ? 1 : 0);
        if (v.exp_done) begin
            check($sformatf("v%0d done_cpu_read_data", idx), done_rdata, v.exp_rdata);
            check($sformatf("v%0d done_stall", idx), {31'b0, done_stall}, 32'd0);
        end
        if (v.exp_rd + v.exp_wr > 0) begin
            check($sformatf("v%0d mem_address", idx), a0, v.addr);
            check($sformatf("v%0d mem_write_data", idx), d0, v.wdata);
            check($sformatf("v%0d strobe_unstable", idx), unstable, 32'd0);
        end
    endtask

    initial begin
        int c0;
        //         rd    wr    addr           wdata          mdata         dly stl rd  wr  exp_rdata      err   done
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 1, 2,  1,  0, 32'h1234_5678, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 3, 4,  0,  3, 32'h0000_0000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h5555_5555, 0, 17, 16, 0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_0001, 32'h0000_0000, 1, 0,  0,  0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1, 0,  0,  0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0022, 32'h0000_5555, 32'h0000_0000, 1, 0,  0,  0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'hFFFF_F000, 32'h0BAD_F00D, 32'hA5A5_5A5A, 2, 3,  2,  0, 32'hA5A5_5A5A, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1, 0,  0,  0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h8765_4321, 16, 17, 16, 0, 32'h8765_4321, 1'b0, 1'b1};

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset in the second ACCESS cycle of a store, with ready arriving at the same moment
        do_reset();
        c0 = wr_commits;
        bus.cpu_write = 1'b1;
        bus.cpu_address = 32'h0000_0024;
        bus.cpu_write_data = 32'h1111_2222;
        @(posedge clock); #1;
        check("abort access1 write_enable", {31'b0, bus.mem_write_enable}, 32'd1);
        @(posedge clock); #1;
        check("abort access2 write_enable", {31'b0, bus.mem_write_enable}, 32'd1);
        bus.mem_ready = 1'b1;
        reset = 1'b0;
        #1;
        check("abort write_enable async", {31'b0, bus.mem_write_enable}, 32'd0);
        check("abort read_enable async", {31'b0, bus.mem_read_enable}, 32'd0);
        check("abort mem_address async", bus.mem_address, 32'd0);
        check("abort stall in reset", {31'b0, bus.stall}, 32'd0);
        @(posedge clock); #1;
        check("abort no write commit", wr_commits - c0, 32'd0);
        check("abort stall held request", {31'b0, bus.stall}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        check("abort idle stall after release", {31'b0, bus.stall}, 32'd1);
        check("abort idle no strobe", {31'b0, bus.mem_write_enable}, 32'd0);
        bus.cpu_write = 1'b0;

        // Back-to-back loads with cpu_read held: IDLE, ACCESS, DONE repeating
        do_reset();
        bus.cpu_read = 1'b1;
        bus.cpu_address = 32'h0000_0030;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            check($sformatf("b2b c%0d read_enable", k), {31'b0, bus.mem_read_enable}, (k % 3 == 1) ? 32'd1 : 32'd0);
            bus.mem_ready = bus.mem_read_enable;
            bus.mem_read_data = 32'h100 + k / 3;
            if (k % 3 == 2) check($sformatf("b2b c%0d cpu_read_data", k), bus.cpu_read_data, 32'h100 + k / 3);
            #1;
            check($sformatf("b2b c%0d stall", k), {31'b0, bus.stall}, (k % 3 != 2) ? 32'd1 : 32'd0);
        end
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b1;
        bus.cpu_address = 32'h0000_0034;
        bus.cpu_write_data = 32'h0000_0077;
        bus.mem_ready = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("b2b store write_enable", {31'b0, bus.mem_write_enable}, 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_read_data = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        check("b2b store holds cpu_read_data", bus.cpu_read_data, 32'h0000_0102);
        bus.cpu_write = 1'b0;
        bus.mem_ready = 1'b0;

        // Sticky error: later valid requests are ignored
        do_reset();
        bus.cpu_read = 1'b1;
        bus.cpu_write = 1'b1;
        bus.cpu_address = 32'h0000_0040;
        #1;
        check("sticky both stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clock); #1;
        check("sticky error set", {31'b0, bus.error}, 32'd1);
        bus.cpu_write = 1'b0;
        #1;
        check("sticky valid load stall", {31'b0, bus.stall}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check($sformatf("sticky c%0d read_enable", k), {31'b0, bus.mem_read_enable}, 32'd0);
        end
        check("sticky error held", {31'b0, bus.error}, 32'd1);
        bus.cpu_read = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_access_master.md
MEMORY_ACCESS_MASTER -- requirements
Module: memory_access_master

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 16, meaning the number of ACCESS cycles without mem_ready before abort.
REQ-002 The block SHALL provide port clock  input  1  pipeline clock; all state updates on posedge.
REQ-003 The block SHALL provide port reset  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL provide port cpu_read  input  1  MEM-stage load request (MemRead from EX/MEM).
REQ-005 The block SHALL provide port cpu_write  input  1  MEM-stage store request (MemWrite from EX/MEM).
REQ-006 The block SHALL provide port cpu_address  input  32  ALU-computed byte address.
REQ-007 The block SHALL provide port cpu_write_data  input  32  store data.
REQ-008 The block SHALL provide port cpu_read_data  output  32  registered load result to MEM/WB.
REQ-009 The block SHALL provide port stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM while high.
REQ-010 The block SHALL provide port mem_address  output  32  registered address to the data memory.
REQ-011 The block SHALL provide port mem_read_enable  output  1  registered read strobe to the data memory.
REQ-012 The block SHALL provide port mem_write_enable  output  1  registered write strobe to the data memory.
REQ-013 The block SHALL provide port mem_write_data  output  32  registered store data to the data memory.
REQ-014 The block SHALL provide port mem_read_data  input  32  read data from the data memory.
REQ-015 The block SHALL provide port mem_ready  input  1  responder completion acknowledge, sampled on posedge.
REQ-016 The block SHALL provide port error  output  1  sticky fault flag.

Function
REQ-017 The block SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-018 In IDLE, a valid request SHALL be exactly one of cpu_read/cpu_write high with cpu_address[1:0]==0 and error low.
REQ-019 On a valid request in IDLE, the block SHALL latch the address, write data and direction, raise exactly one strobe, clear the timer, and enter ACCESS at the next posedge.
REQ-020 stall SHALL be combinational: high when (IDLE and valid request) or ACCESS; low in DONE and otherwise.
REQ-021 In ACCESS, the strobe, mem_address and mem_write_data SHALL hold constant until mem_ready is sampled high.
REQ-022 On mem_ready high in ACCESS, the block SHALL drop the strobe, capture mem_read_data into cpu_read_data on reads (hold the old value on writes), and enter DONE.
REQ-023 Minimum latency SHALL be request-to-DONE in 2 posedges (responder ready on the first ACCESS cycle).
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE; requests are not sampled in DONE, which prevents reissuing the same EX/MEM contents.
REQ-025 The timer SHALL count ACCESS cycles, saturating; when it reaches TIMEOUT with mem_ready low, the block SHALL set error, drop the strobe, load cpu_read_data with 0, and enter DONE.
REQ-026 cpu_read and cpu_write both high in IDLE SHALL set error, issue no access and leave stall low.
REQ-027 A misaligned address (cpu_address[1:0]!=0) with a single request SHALL set error, issue no access and leave stall low.
REQ-028 Once set, error SHALL remain high until reset; while error is high, all requests SHALL be ignored.
REQ-029 mem_ready outside ACCESS SHALL be ignored.
REQ-030 mem_address SHALL carry the full 32-bit cpu_address unmodified; range checking on [31:12] belongs to the responder.
REQ-031 mem_read_enable and mem_write_enable SHALL never be high simultaneously.

Reset
REQ-032 When reset is low, the block SHALL immediately set: state IDLE, mem_read_enable 0, mem_write_enable 0, mem_address 0, mem_write_data 0, cpu_read_data 0, error 0, timer 0.
REQ-033 stall SHALL be 0 while reset is low, regardless of cpu inputs.
REQ-034 Reset asserted in ACCESS SHALL abort the transaction with no partial write; the strobe drops asynchronously.

Structure
REQ-035 The shared constants header SHALL hold the FSM state encodings (2 bits) and the TIMEOUT default.
REQ-036 The timer SHALL be a sub-module access_timer (clear, enable, saturating count, expired output).

Verification
REQ-037 Load at 0x0000_0010 with the responder ready 1 cycle after the strobe and data 0x1234_5678 -> stall high for 2 cycles, cpu_read_data=0x1234_5678 in DONE, error 0.
REQ-038 Store of 0xCAFE_F00D to 0x0000_0020 with a 3-cycle ready delay -> mem_write_enable held 3 cycles with address and data stable; stall deasserts in DONE.
REQ-039 Load with mem_ready never asserted, TIMEOUT=16 -> error at ACCESS cycle 16, cpu_read_data=0, subsequent requests ignored.
REQ-040 cpu_read=cpu_write=1, or a load at 0x0000_0013 -> error=1, no strobe, stall=0.
REQ-041 Reset pulled low in the second ACCESS cycle of a store -> strobes 0 immediately, state IDLE, memory contents unchanged.
REQ-042 Back-to-back loads held on cpu_read across DONE -> exactly one access per request, with one DONE cycle between accesses.
